// File: rtl/neptune_pkg.sv
// Shared constants for the guitar-tuner tile: window lengths, note bands,
// note targets, display glyphs and proximity thresholds.
package neptune_pkg;

  localparam int WIN_W   = 12;
  localparam int FREQ_W  = 9;
  localparam int DELTA_W = FREQ_W + 1;
  localparam int SEG_W   = 7;

  // Window lengths in clock cycles; each equals one second at the nominal clock.
  localparam logic [WIN_W-1:0] WIN_LEN_1K  = 12'd1000;
  localparam logic [WIN_W-1:0] WIN_LEN_2K  = 12'd2000;
  localparam logic [WIN_W-1:0] WIN_LEN_4K  = 12'd4000;
  localparam logic [WIN_W-1:0] WIN_LEN_3K3 = 12'd3333;

  typedef enum logic [2:0] {
    NOTE_NONE,
    NOTE_E2,
    NOTE_A2,
    NOTE_D3,
    NOTE_G3,
    NOTE_B3,
    NOTE_E4
  } note_t;

  // Lower bound of each note band; E4_HI closes the last band.
  localparam logic [FREQ_W-1:0] E2_LO = 9'd60;
  localparam logic [FREQ_W-1:0] A2_LO = 9'd96;
  localparam logic [FREQ_W-1:0] D3_LO = 9'd128;
  localparam logic [FREQ_W-1:0] G3_LO = 9'd171;
  localparam logic [FREQ_W-1:0] B3_LO = 9'd221;
  localparam logic [FREQ_W-1:0] E4_LO = 9'd288;
  localparam logic [FREQ_W-1:0] E4_HI = 9'd400;

  localparam logic [FREQ_W-1:0] E2_TGT = 9'd82;
  localparam logic [FREQ_W-1:0] A2_TGT = 9'd110;
  localparam logic [FREQ_W-1:0] D3_TGT = 9'd147;
  localparam logic [FREQ_W-1:0] G3_TGT = 9'd196;
  localparam logic [FREQ_W-1:0] B3_TGT = 9'd247;
  localparam logic [FREQ_W-1:0] E4_TGT = 9'd330;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_G     = 7'h3D;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;

  localparam logic [SEG_W-1:0] PROX_FLAT_FAR   = 7'h30;
  localparam logic [SEG_W-1:0] PROX_FLAT_MID   = 7'h10;
  localparam logic [SEG_W-1:0] PROX_FLAT_NEAR  = 7'h08;
  localparam logic [SEG_W-1:0] PROX_IN_TUNE    = 7'h40;
  localparam logic [SEG_W-1:0] PROX_SHARP_NEAR = 7'h01;
  localparam logic [SEG_W-1:0] PROX_SHARP_MID  = 7'h04;
  localparam logic [SEG_W-1:0] PROX_SHARP_FAR  = 7'h06;

  // Upper (inclusive) delta of each proximity band, flat to sharp.
  localparam logic signed [DELTA_W-1:0] THR_FLAT_FAR   = -10'sd9;
  localparam logic signed [DELTA_W-1:0] THR_FLAT_MID   = -10'sd4;
  localparam logic signed [DELTA_W-1:0] THR_FLAT_NEAR  = -10'sd2;
  localparam logic signed [DELTA_W-1:0] THR_IN_TUNE    = 10'sd1;
  localparam logic signed [DELTA_W-1:0] THR_SHARP_NEAR = 10'sd3;
  localparam logic signed [DELTA_W-1:0] THR_SHARP_MID  = 10'sd8;

  function automatic logic [WIN_W-1:0] window_last(input logic [1:0] cfg);
    logic [WIN_W-1:0] len;
    case (cfg)
      2'b00:   len = WIN_LEN_1K;
      2'b01:   len = WIN_LEN_2K;
      2'b10:   len = WIN_LEN_4K;
      default: len = WIN_LEN_3K3;
    endcase
    return len - 12'd1;
  endfunction

endpackage

// File: rtl/neptune_freq_counter.sv
// Synchronises the external pulse, counts rising edges over a one-second
// window and latches the count, pulsing valid for one cycle after each window.
module neptune_freq_counter
  import neptune_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        clk_config,
  input  logic              input_pulse,
  output logic [FREQ_W-1:0] freq,
  output logic              valid
);

  logic              sync_p0;
  logic              sync_p1;
  logic              prev_p2;
  logic              rise;
  logic              win_end;
  logic [WIN_W-1:0]  win_cnt;
  logic [FREQ_W-1:0] edge_cnt;

  function automatic logic [FREQ_W-1:0] sat_inc(input logic [FREQ_W-1:0] v);
    return (v == {FREQ_W{1'b1}}) ? v : v + 9'd1;
  endfunction

  assign rise = sync_p1 & ~prev_p2;
  // Compare against the live config so a shortened window ends at once.
  assign win_end = (win_cnt >= window_last(clk_config));

  // Synchroniser and edge-detect stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= input_pulse;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  // Window / edge counting stage
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
      freq     <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= win_end;
      if (win_end) begin
        win_cnt  <= '0;
        freq     <= edge_cnt;
        // An edge landing on the closing cycle belongs to the next window.
        edge_cnt <= {{(FREQ_W-1){1'b0}}, rise};
      end else begin
        win_cnt <= win_cnt + 12'd1;
        if (rise) begin
          edge_cnt <= sat_inc(edge_cnt);
        end
      end
    end
  end

endmodule

// File: rtl/psychogenic_neptune_prop.sv
// Guitar-tuner tile top: decodes the measured frequency into a note glyph and
// a tuning-proximity glyph, and time-multiplexes them onto one 7-seg digit.
module psychogenic_neptune_prop
  import neptune_pkg::*;
(
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic                      clk;
  logic                      rst;
  logic [1:0]                clk_config;
  logic                      input_pulse;
  logic                      unused_io;
  logic [FREQ_W-1:0]         freq_p0;
  logic                      vld_p0;
  note_t                     note_sel;
  logic signed [DELTA_W-1:0] delta;
  logic [SEG_W-1:0]          note_glyph_p1;
  logic [SEG_W-1:0]          prox_glyph_p1;
  logic [SEG_W-1:0]          seg_p2;
  logic                      prox_select;
  logic                      prox_next;

  assign clk         = io_in[0];
  assign rst         = io_in[1];
  assign clk_config  = io_in[3:2];
  assign input_pulse = io_in[4];
  assign unused_io   = &{1'b0, io_in[7:5]};

  neptune_freq_counter u_freq (
    .clk         (clk),
    .rst         (rst),
    .clk_config  (clk_config),
    .input_pulse (input_pulse),
    .freq        (freq_p0),
    .valid       (vld_p0)
  );

  function automatic note_t classify(input logic [FREQ_W-1:0] f);
    if (f < E2_LO || f > E4_HI) return NOTE_NONE;
    if (f < A2_LO)              return NOTE_E2;
    if (f < D3_LO)              return NOTE_A2;
    if (f < G3_LO)              return NOTE_D3;
    if (f < B3_LO)              return NOTE_G3;
    if (f < E4_LO)              return NOTE_B3;
    return NOTE_E4;
  endfunction

  function automatic logic [FREQ_W-1:0] note_target(input note_t n);
    case (n)
      NOTE_E2: return E2_TGT;
      NOTE_A2: return A2_TGT;
      NOTE_D3: return D3_TGT;
      NOTE_G3: return G3_TGT;
      NOTE_B3: return B3_TGT;
      NOTE_E4: return E4_TGT;
      default: return '0;
    endcase
  endfunction

  function automatic logic [SEG_W-1:0] note_code(input note_t n);
    case (n)
      NOTE_E2, NOTE_E4: return SEG_E;
      NOTE_A2:          return SEG_A;
      NOTE_D3:          return SEG_D;
      NOTE_G3:          return SEG_G;
      NOTE_B3:          return SEG_B;
      default:          return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [SEG_W-1:0] prox_code(input logic signed [DELTA_W-1:0] d);
    if (d <= THR_FLAT_FAR)   return PROX_FLAT_FAR;
    if (d <= THR_FLAT_MID)   return PROX_FLAT_MID;
    if (d <= THR_FLAT_NEAR)  return PROX_FLAT_NEAR;
    if (d <= THR_IN_TUNE)    return PROX_IN_TUNE;
    if (d <= THR_SHARP_NEAR) return PROX_SHARP_NEAR;
    if (d <= THR_SHARP_MID)  return PROX_SHARP_MID;
    return PROX_SHARP_FAR;
  endfunction

  always_comb begin
    note_sel = classify(freq_p0);
    delta    = $signed({1'b0, freq_p0}) - $signed({1'b0, note_target(note_sel)});
  end

  // Glyph stage: refreshed once per completed window, held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      note_glyph_p1 <= SEG_BLANK;
      prox_glyph_p1 <= SEG_BLANK;
    end else if (vld_p0) begin
      note_glyph_p1 <= note_code(note_sel);
      prox_glyph_p1 <= (note_sel == NOTE_NONE) ? SEG_BLANK : prox_code(delta);
    end
  end

  assign prox_next = ~prox_select;

  // Display stage: segments registered together with the phase they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      prox_select <= 1'b0;
      seg_p2      <= SEG_BLANK;
    end else begin
      prox_select <= prox_next;
      seg_p2      <= prox_next ? prox_glyph_p1 : note_glyph_p1;
    end
  end

  assign io_out = {prox_select, seg_p2};

endmodule

// File: tb/tb_psychogenic_neptune_prop.sv
// Bench for the guitar-tuner tile: table of single-window cases plus
// hand-written multi-window, config-length and mid-window reset sequences.
module tb_psychogenic_neptune_prop;

  typedef struct {
    logic [1:0] cfg;
    int         edges;
    logic [6:0] note;
    logic [6:0] prox;
  } vec_t;

  typedef struct packed {
    logic [6:0] note;
    logic [6:0] prox;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cfg = 2'b00;
  logic       pulse = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sbq[$];
  vec_t       vecs[18];

  assign io_in = {3'b000, pulse, cfg, rst, clk};

  psychogenic_neptune_prop dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int win_len(input logic [1:0] c);
    case (c)
      2'b00:   return 1000;
      2'b01:   return 2000;
      2'b10:   return 4000;
      default: return 3333;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] c, input string name);
    @(negedge clk);
    rst   = 1'b1;
    pulse = 1'b0;
    cfg   = c;
    repeat (3) @(negedge clk);
    check({name, " reset seg"}, {1'b0, io_out[6:0]}, 8'h00);
    check({name, " reset prox_select"}, {7'b0, io_out[7]}, 8'h00);
    rst = 1'b0;
  endtask

  task automatic drive_edges(input int start, input int n);
    wait_until(start);
    for (int i = 0; i < n; i++) begin
      pulse = 1'b1;
      @(negedge clk);
      pulse = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_window(input string name);
    exp_t e;
    logic p0;
    logic p1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got seg %02h expected an entry", name, io_out[6:0]);
      return;
    end
    e  = sbq.pop_front();
    p0 = io_out[7];
    check({name, p0 ? " prox" : " note"}, {1'b0, io_out[6:0]},
          {1'b0, p0 ? e.prox : e.note});
    @(negedge clk);
    p1 = io_out[7];
    check({name, p1 ? " prox" : " note"}, {1'b0, io_out[6:0]},
          {1'b0, p1 ? e.prox : e.note});
    check({name, " prox_select toggle"}, {7'b0, p1}, {7'b0, ~p0});
  endtask

  initial begin
    vecs[0]  = '{2'b00,   0, 7'h00, 7'h00};
    vecs[1]  = '{2'b00, 110, 7'h77, 7'h40};
    vecs[2]  = '{2'b00,  59, 7'h00, 7'h00};
    vecs[3]  = '{2'b00, 401, 7'h00, 7'h00};
    vecs[4]  = '{2'b10, 600, 7'h00, 7'h00};
    vecs[5]  = '{2'b00,  60, 7'h79, 7'h30};
    vecs[6]  = '{2'b00, 400, 7'h79, 7'h06};
    vecs[7]  = '{2'b00,  96, 7'h77, 7'h30};
    vecs[8]  = '{2'b00, 127, 7'h77, 7'h06};
    vecs[9]  = '{2'b00, 128, 7'h5E, 7'h30};
    vecs[10] = '{2'b00, 144, 7'h5E, 7'h08};
    vecs[11] = '{2'b00, 150, 7'h5E, 7'h01};
    vecs[12] = '{2'b00, 190, 7'h3D, 7'h10};
    vecs[13] = '{2'b00, 201, 7'h3D, 7'h04};
    vecs[14] = '{2'b00, 221, 7'h7C, 7'h30};
    vecs[15] = '{2'b11, 247, 7'h7C, 7'h40};
    vecs[16] = '{2'b00, 288, 7'h79, 7'h30};
    vecs[17] = '{2'b01, 330, 7'h79, 7'h40};

    for (int v = 0; v < 18; v++) begin
      string nm;
      int    len;
      nm  = $sformatf("vec%0d_%0dHz", v, vecs[v].edges);
      len = win_len(vecs[v].cfg);
      do_reset(vecs[v].cfg, nm);
      drive_edges(10, vecs[v].edges);
      sbq.push_back('{vecs[v].note, vecs[v].prox});
      wait_until(len + 5);
      check_window(nm);
    end

    // Back-to-back windows: in tune, then sharp by 10
    do_reset(2'b00, "e2_seq");
    drive_edges(10, 82);
    sbq.push_back('{7'h79, 7'h40});
    wait_until(1005);
    check_window("e2_seq w0");
    drive_edges(1010, 92);
    sbq.push_back('{7'h79, 7'h06});
    wait_until(2005);
    check_window("e2_seq w1");

    // Long window: nothing latched at 1000 cycles, result at 4000
    do_reset(2'b10, "d3_long");
    drive_edges(10, 143);
    sbq.push_back('{7'h00, 7'h00});
    wait_until(1005);
    check_window("d3_long early");
    sbq.push_back('{7'h5E, 7'h10});
    wait_until(4005);
    check_window("d3_long done");

    // Reset mid-window discards the partial count
    do_reset(2'b00, "g3_rst");
    drive_edges(10, 100);
    wait_until(300);
    do_reset(2'b00, "g3_rst mid");
    drive_edges(10, 196);
    sbq.push_back('{7'h00, 7'h00});
    wait_until(500);
    check_window("g3_rst before");
    sbq.push_back('{7'h3D, 7'h40});
    wait_until(1005);
    check_window("g3_rst after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
